// File: rtl/vec_fetch_pkg.sv
// Shared definitions for vec_fetch: FSM states, bus constants and checksum width.
// Optional checksum logic is enabled with the VFETCH_CHECKSUM_EN macro.
package vec_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0]  BYTEENABLE = 2'b11;
  localparam int unsigned CSUM_WIDTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two. Head is zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // A write into a full FIFO is accepted when the head is popped in the same cycle.
  assign wr_ok = wr_en && !flush && (!full || rd_en);
  assign rd_ok = rd_en && !flush && !empty;

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_fetch.sv
// Test-vector fetcher: reads SRAM words over the tr_* port, packs them into vectors
// and streams them through a FIFO. Optional run checksum via VFETCH_CHECKSUM_EN.
module vec_fetch
  import vec_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned WORDS_PER_VEC = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [CNT_WIDTH-1:0]                vec_count,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               tr_address,
  output logic [1:0]                          tr_byteenable,
  output logic                                tr_read,
  input  logic [DATA_WIDTH-1:0]               tr_readdata,
  output logic                                tr_write,
  output logic [DATA_WIDTH-1:0]               tr_writedata,
  input  logic                                tr_waitrequest,
  output logic [DATA_WIDTH*WORDS_PER_VEC-1:0] vec_data,
  output logic                                vec_valid,
  input  logic                                vec_ready,
  output logic [CSUM_WIDTH-1:0]               checksum
);

  localparam int unsigned VW = DATA_WIDTH * WORDS_PER_VEC;
  localparam int unsigned IW = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   vec_left;
  logic [IW-1:0]          word_idx;
  logic [VW-1:0]          asm_vec;
  logic [VW-1:0]          asm_next;
  logic                   asm_active;
  logic                   wr_pend;
  logic                   abort_pend;
  logic                   xfer;
  logic                   stall;
  logic                   abort_apply;
  logic                   last_word;
  logic                   room;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PW:0]            fifo_count;
  logic [PW+1:0]          used;

  assign tr_byteenable = BYTEENABLE;
  assign tr_write      = 1'b0;
  assign tr_writedata  = '0;

  assign xfer        = tr_read && !tr_waitrequest;
  assign stall       = tr_read && tr_waitrequest;
  assign abort_apply = (abort || abort_pend) && !stall;
  assign last_word   = (word_idx == IW'(WORDS_PER_VEC - 1));

  // Slots held = stored vectors + vector in flight to the FIFO + vector being assembled.
  assign used = {1'b0, fifo_count} + {{(PW+1){1'b0}}, wr_pend} + {{(PW+1){1'b0}}, asm_active};
  assign room = !fifo_full && (used < (PW+2)'(FIFO_DEPTH));

  always_comb begin
    asm_next = asm_vec;
    for (int unsigned i = 0; i < WORDS_PER_VEC; i++)
      if (word_idx == IW'(i)) asm_next[i*DATA_WIDTH +: DATA_WIDTH] = tr_readdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      tr_read    <= 1'b0;
      tr_address <= '0;
      vec_left   <= '0;
      word_idx   <= '0;
      asm_vec    <= '0;
      asm_active <= 1'b0;
      wr_pend    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_pend <= 1'b0;
      if (xfer) asm_vec <= asm_next;
      if (state != IDLE && abort_apply) begin
        state      <= IDLE;
        busy       <= 1'b0;
        tr_read    <= 1'b0;
        word_idx   <= '0;
        asm_active <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        if (state != IDLE && abort) abort_pend <= 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              if (vec_count != '0) begin
                state      <= FETCH;
                busy       <= 1'b1;
                vec_left   <= vec_count;
                tr_read    <= 1'b1;
                tr_address <= base_addr;
                word_idx   <= '0;
                asm_active <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (xfer) begin
              if (last_word) begin
                wr_pend    <= 1'b1;
                word_idx   <= '0;
                vec_left   <= vec_left - 1'b1;
                asm_active <= 1'b0;
                if (vec_left == CNT_WIDTH'(1)) begin
                  tr_read <= 1'b0;
                  state   <= DRAIN;
                end else if (room) begin
                  tr_address <= tr_address + 1'b1;
                  asm_active <= 1'b1;
                end else begin
                  tr_read <= 1'b0;
                end
              end else begin
                word_idx   <= word_idx + 1'b1;
                tr_address <= tr_address + 1'b1;
              end
            end else if (!tr_read && room) begin
              tr_read    <= 1'b1;
              tr_address <= tr_address + 1'b1;
              asm_active <= 1'b1;
            end
          end
          DRAIN: begin
            if (!wr_pend && fifo_empty) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              abort_pend <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (state != IDLE && abort_apply),
    .wr_en   (wr_pend),
    .wr_data (asm_vec),
    .rd_en   (vec_ready),
    .rd_data (vec_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign vec_valid = !fifo_empty;

`ifdef VFETCH_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] csum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   csum <= '0;
    else if (start && state == IDLE) csum <= '0;
    else if (xfer)                  csum <= csum + CSUM_WIDTH'(tr_readdata);
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule
